// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the synchronous instruction
// SRAM, and hands {pc, pc_en} to Decode over the FD valid/allowin handshake.
// A taken branch released by Decode redirects the PC and turns the slot
// handed off in the same cycle into a bubble (pc_en=0).
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h1C000000,
    parameter int          FD_BUS_WID = 33,
    parameter int          BR_BUS_WID = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  D_allowin,
    input  logic [BR_BUS_WID-1:0] Branch_BUS,
    output logic                  FD_valid,
    output logic [FD_BUS_WID-1:0] FD_BUS,
    output logic                  inst_sram_en,
    output logic [3:0]            inst_sram_we,
    output logic [31:0]           inst_sram_addr,
    output logic [31:0]           inst_sram_wdata
);

    logic        F_valid;
    logic [31:0] pc_F;
    logic        d_live;     // slot currently in Decode is valid with pc_en=1

    logic        br_taken;
    logic [31:0] br_target;
    logic        handoff;
    logic        br_eff;
    logic        pc_en_out;

    assign br_taken  = Branch_BUS[BR_BUS_WID-1];
    assign br_target = Branch_BUS[31:0];

    // A branch counts only when Decode holds a live slot and is releasing it;
    // a stalled Decode's br_taken is re-sampled once allowin rises.
    assign FD_valid  = F_valid & ~rst;
    assign handoff   = FD_valid & D_allowin;
    assign br_eff    = br_taken & d_live & D_allowin;
    assign pc_en_out = ~br_eff;

    // On a stall or a cancelled handoff the SRAM is not read, so its rdata
    // holds and Decode re-sees the previous word, gated by pc_en=0.
    assign inst_sram_en    = handoff & ~br_eff;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_addr  = pc_F;
    assign inst_sram_wdata = 32'b0;

    assign FD_BUS = {pc_F, pc_en_out};

    // Fetch state: valid flag, PC redirect/advance/hold, Decode liveness.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every update
        // in this block sees the pre-edge values of F_valid, pc_F and d_live.
        if (rst) begin
            F_valid <= 1'b0;
            pc_F    <= RESET_PC;
            d_live  <= 1'b0;
        end else begin
            F_valid <= 1'b1;
            if (br_eff) begin
                pc_F <= br_target;
            end else if (handoff) begin
                pc_F <= pc_F + 32'd4;
            end
            if (D_allowin) begin
                d_live <= FD_valid & pc_en_out;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes the expected FD slot for
// every valid cycle; per-DUT monitors pop and compare on the falling edge.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] addr;
        logic        pc_en;
        logic        en;
    } exp_t;

    logic        clk;
    logic        rst, rst2;
    logic        allowin;
    logic        br_taken;
    logic [31:0] br_tgt;

    logic        fd_valid, fd_valid2;
    logic [32:0] fd_bus, fd_bus2;
    logic        en, en2;
    logic [3:0]  we, we2;
    logic [31:0] addr, addr2, wdata, wdata2;

    exp_t q1[$];
    exp_t q2[$];
    int   total = 0;
    int   bad   = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .D_allowin      (allowin),
        .Branch_BUS     ({br_taken, br_tgt}),
        .FD_valid       (fd_valid),
        .FD_BUS         (fd_bus),
        .inst_sram_en   (en),
        .inst_sram_we   (we),
        .inst_sram_addr (addr),
        .inst_sram_wdata(wdata)
    );

    fetch_stage #(.RESET_PC(32'hFFFFFFF8)) dut_wrap (
        .clk            (clk),
        .rst            (rst2),
        .D_allowin      (1'b1),
        .Branch_BUS     (33'd0),
        .FD_valid       (fd_valid2),
        .FD_BUS         (fd_bus2),
        .inst_sram_en   (en2),
        .inst_sram_we   (we2),
        .inst_sram_addr (addr2),
        .inst_sram_wdata(wdata2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and apply inputs just after the rising edge.
    task automatic step(input logic r, input logic r2, input logic a,
                        input logic bt, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        rst      = r;
        rst2     = r2;
        allowin  = a;
        br_taken = bt;
        br_tgt   = tgt;
    endtask

    task automatic exp1(input logic [31:0] a, input logic p, input logic e);
        exp_t x;
        x.addr = a; x.pc_en = p; x.en = e;
        q1.push_back(x);
    endtask

    task automatic exp2(input logic [31:0] a);
        exp_t x;
        x.addr = a; x.pc_en = 1'b1; x.en = 1'b1;
        q2.push_back(x);
    endtask

    // Monitor for the main DUT.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_fd_valid", 64'(fd_valid), 64'd0);
            check("rst_en", 64'(en), 64'd0);
        end else if (fd_valid) begin
            if (q1.size() == 0) begin
                check("unexpected_slot", 64'(fd_bus), 64'd0);
            end else begin
                exp_t x;
                x = q1.pop_front();
                check("fd_bus", 64'(fd_bus), 64'({x.addr, x.pc_en}));
                check("sram_addr", 64'(addr), 64'(x.addr));
                check("sram_en", 64'(en), 64'(x.en));
                check("sram_we_wdata", 64'({we, wdata}), 64'd0);
            end
        end else begin
            check("idle_en", 64'(en), 64'd0);
        end
    end

    // Monitor for the wrap-around DUT.
    always @(negedge clk) begin
        if (rst2) begin
            check("wrap_rst_fd_valid", 64'(fd_valid2), 64'd0);
        end else if (fd_valid2) begin
            if (q2.size() == 0) begin
                check("wrap_unexpected_slot", 64'(fd_bus2), 64'd0);
            end else begin
                exp_t x;
                x = q2.pop_front();
                check("wrap_fd_bus", 64'(fd_bus2), 64'({x.addr, x.pc_en}));
                check("wrap_sram_en", 64'(en2), 64'(x.en));
            end
        end else begin
            check("wrap_idle_en", 64'(en2), 64'd0);
        end
    end

    initial begin
        rst = 1'b1; rst2 = 1'b1; allowin = 1'b1; br_taken = 1'b0; br_tgt = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        // Reset release: one idle cycle, then sequential fetch
        rst = 1'b0;
        step(0, 1, 1, 0, 0);           exp1(32'h1C000000, 1, 1);
        step(0, 1, 1, 0, 0);           exp1(32'h1C000004, 1, 1);
        // Stall three cycles at 0x1C000008
        step(0, 1, 0, 0, 0);           exp1(32'h1C000008, 1, 0);
        step(0, 1, 0, 0, 0);           exp1(32'h1C000008, 1, 0);
        step(0, 1, 0, 0, 0);           exp1(32'h1C000008, 1, 0);
        step(0, 1, 1, 0, 0);           exp1(32'h1C000008, 1, 1);
        step(0, 1, 1, 0, 0);           exp1(32'h1C00000C, 1, 1);
        // Taken branch from live Decode slot: bubble, then target
        step(0, 1, 1, 1, 32'h1C000100); exp1(32'h1C000010, 0, 0);
        // Stale br_taken from the cancelled slot is ignored
        step(0, 1, 1, 1, 32'h1C000200); exp1(32'h1C000100, 1, 1);
        step(0, 1, 1, 0, 0);           exp1(32'h1C000104, 1, 1);
        // Branch under stall: no redirect until allowin rises
        step(0, 1, 0, 1, 32'h1C000300); exp1(32'h1C000108, 1, 0);
        step(0, 1, 0, 1, 32'h1C000300); exp1(32'h1C000108, 1, 0);
        step(0, 1, 1, 1, 32'h1C000300); exp1(32'h1C000108, 0, 0);
        step(0, 1, 1, 0, 0);           exp1(32'h1C000300, 1, 1);
        step(0, 1, 1, 0, 0);           exp1(32'h1C000304, 1, 1);
        // Branch to 0x1C000040, then reset there with a branch in flight
        step(0, 1, 1, 1, 32'h1C000040); exp1(32'h1C000308, 0, 0);
        step(1, 1, 1, 1, 32'h1C000500);
        step(0, 1, 1, 1, 32'h1C000600);
        step(0, 1, 1, 1, 32'h1C000600); exp1(32'h1C000000, 1, 1);
        step(0, 1, 1, 0, 0);           exp1(32'h1C000004, 1, 1);
        // Wrap-around on the second instance; main DUT parked in reset
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);           exp2(32'hFFFFFFF8);
        step(1, 0, 1, 0, 0);           exp2(32'hFFFFFFFC);
        step(1, 0, 1, 0, 0);           exp2(32'h00000000);
        step(1, 0, 1, 0, 0);           exp2(32'h00000004);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("q2_drained", 64'(q2.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the LoongArch pipeline, upstream of Decode.
- Owns the PC, drives the synchronous instruction SRAM, and hands {pc, pc_en} to Decode over the FD valid/allowin handshake.
- Consumes Decode's Branch_BUS to redirect.
- Cancels the wrong-path slot that is handed off in the same cycle as a taken branch, so the slot becomes a pipeline bubble.

Parameters:
- RESET_PC, 32'h1C000000, first PC fetched after reset.
- FD_BUS_WID, 33, width of {pc[31:0], pc_en}.
- BR_BUS_WID, 33, width of {br_taken, br_target[31:0]}.

Ports:
- clk  in  1  clock; one clock, all logic on posedge.
- rst  in  1  reset is synchronous and active-high.
- D_allowin  in  1  Decode can accept the FD_BUS word this cycle.
- Branch_BUS  in  BR_BUS_WID  {br_taken, br_target}, combinational from Decode for the instruction it currently holds.
- FD_valid  out  1  FD_BUS carries a fetch slot.
- FD_BUS  out  FD_BUS_WID  {pc_F, pc_en_out}.
- inst_sram_en  out  1  SRAM read enable; data is returned the next cycle.
- inst_sram_we  out  4  tied 4'b0.
- inst_sram_addr  out  32  equals pc_F.
- inst_sram_wdata  out  32  tied 32'b0.

Behaviour:
- State registers:
  - F_valid.
  - pc_F[31:0].
  - d_live: the slot now in Decode is valid and has pc_en=1.
- Reset (rst=1 at posedge):
  - F_valid<=0, pc_F<=RESET_PC, d_live<=0.
  - While rst=1: FD_valid=0 and inst_sram_en=0 combinationally.
- First posedge with rst=0: F_valid<=1. F_valid then stays 1 until the next reset.
- FD_valid = F_valid & ~rst.
- handoff = FD_valid & D_allowin.
- br_eff = Branch_BUS[32] & d_live & D_allowin.
  - A taken branch is acted on only in the cycle Decode releases it.
  - br_taken from a stalled Decode is ignored; it is sampled again when D_allowin rises.
  - br_taken from a cancelled or empty Decode slot is always ignored.
- pc_en_out = ~br_eff.
- inst_sram_en = handoff & ~br_eff.
  - On a stall, or in a cancelled handoff, the SRAM is not read. Its rdata holds, so Decode re-sees the previous instruction with pc_en=0. That gates gr_we; a branch has mem_we=0.
- inst_sram_addr = pc_F always; there is no extra latency.
- PC update at posedge, first match wins:
  - br_eff: pc_F<=br_target. This applies whether or not a handoff occurs.
  - handoff: pc_F<=pc_F+32'd4. Modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
  - otherwise: pc_F holds.
- d_live update at posedge:
  - If D_allowin=1: d_live <= FD_valid & pc_en_out.
  - Else: hold.
- Simultaneous branch and handoff: the sequential slot is delivered with pc_en=0, and the branch target is fetched the following cycle with pc_en=1. Exactly one bubble per taken branch.
- br_target[1:0] is not checked; misalignment is out of scope.
- Reset mid-operation: everything returns to the reset state in one cycle. Any branch in flight is discarded.

Test Plan:
- Reset release: rst=1 for 3 cycles, D_allowin=1 → FD_valid=0 and en=0 during reset. After release, addr sequence is 0x1C000000, 0x1C000004, 0x1C000008, each with en=1 and pc_en=1.
- Stall: D_allowin=0 for 3 cycles while pc_F=0x1C000008 → en=0, FD_BUS held at {0x1C000008,1}. On D_allowin=1, en=1 and the next address is 0x1C00000C.
- Taken branch: Decode holds the live branch at 0x1C000004 with br_taken=1, target 0x1C000100, D_allowin=1 → that cycle FD_BUS={0x1C000008,0} and en=0. Next cycle addr=0x1C000100, pc_en=1, en=1. A stale br_taken=1 in that cycle causes no redirect.
- Branch under stall: br_taken=1, D_allowin=0 for 2 cycles → pc_F held and no redirect. When D_allowin=1, redirect to the target one cycle later.
- Reset mid-stream: rst=1 at pc_F=0x1C000040 with br_taken=1 → next cycle FD_valid=0 and d_live=0. After release, fetch restarts at 0x1C000000.
- Wrap: RESET_PC=0xFFFFFFF8 with D_allowin=1 → addr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
